// File: rtl/exec_pkg.sv
// Shared definitions for the execute stage: opcode map, flag bit
// positions and the control record held in the output stage.
package exec_pkg;

    localparam int OP_W = 5;

    localparam logic [OP_W-1:0] OP_ADD    = 5'b00000;
    localparam logic [OP_W-1:0] OP_SUB    = 5'b00001;
    localparam logic [OP_W-1:0] OP_ADDI   = 5'b00010;
    localparam logic [OP_W-1:0] OP_SHLLI  = 5'b00011;
    localparam logic [OP_W-1:0] OP_SHRLI  = 5'b00100;
    localparam logic [OP_W-1:0] OP_LOADI  = 5'b00101;
    localparam logic [OP_W-1:0] OP_LOAD   = 5'b00110;
    localparam logic [OP_W-1:0] OP_STORE  = 5'b00111;
    localparam logic [OP_W-1:0] OP_CMP    = 5'b01000;
    localparam logic [OP_W-1:0] OP_JUMP   = 5'b01001;
    localparam logic [OP_W-1:0] OP_JUMPL  = 5'b01010;
    localparam logic [OP_W-1:0] OP_JUMPG  = 5'b01011;
    localparam logic [OP_W-1:0] OP_JUMPE  = 5'b01100;
    localparam logic [OP_W-1:0] OP_JUMPNE = 5'b01101;
    localparam logic [OP_W-1:0] OP_JUMPLI = 5'b01110;
    localparam logic [OP_W-1:0] OP_RET    = 5'b01111;
    localparam logic [OP_W-1:0] OP_MOV    = 5'b10000;

    // Bit positions inside the {L,G,E} compare-flag register
    localparam int FLAG_L = 2;
    localparam int FLAG_G = 1;
    localparam int FLAG_E = 0;

    // Single-bit controls carried by the output stage; data fields are
    // width-parametrised and therefore live next to this in the top.
    typedef struct packed {
        logic we;
        logic mem_rd;
        logic mem_wr;
        logic br_taken;
        logic illegal;
    } exec_ctrl_t;

endpackage

// File: rtl/exec_alu.sv
// Combinational datapath of the execute stage: result, enables, branch
// resolution against the current flags, and next flag value for CMP.
module exec_alu
    import exec_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int IMM_W  = 5
) (
    input  logic [OP_W-1:0]   op,
    input  logic [DATA_W-1:0] src,
    input  logic [DATA_W-1:0] dst,
    input  logic [IMM_W-1:0]  imm,
    input  logic [DATA_W-1:0] npc,
    input  logic [2:0]        flags,
    output logic [DATA_W-1:0] result,
    output logic [DATA_W-1:0] store_data,
    output logic              we,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic              taken,
    output logic [DATA_W-1:0] target,
    output logic              illegal,
    output logic [2:0]        next_flags
);

    logic [DATA_W-1:0] imm_z;
    logic [DATA_W-1:0] imm_s;
    logic [DATA_W-1:0] br_tgt;

    // Decode the opcode; shifts by >= DATA_W fall out as 0 from the shift operator
    always_comb begin
        imm_z      = {{(DATA_W-IMM_W){1'b0}}, imm};
        imm_s      = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
        br_tgt     = npc + imm_s;
        result     = '0;
        store_data = '0;
        we         = 1'b0;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        taken      = 1'b0;
        target     = '0;
        illegal    = 1'b0;
        next_flags = flags;
        case (op)
            OP_ADD:    begin result = src + dst;    we = 1'b1; end
            OP_SUB:    begin result = src - dst;    we = 1'b1; end
            OP_ADDI:   begin result = src + imm_z;  we = 1'b1; end
            OP_SHLLI:  begin result = src << imm_z; we = 1'b1; end
            OP_SHRLI:  begin result = src >> imm_z; we = 1'b1; end
            OP_LOADI:  begin result = imm_z;        we = 1'b1; end
            OP_MOV:    begin result = dst;          we = 1'b1; end
            OP_LOAD:   begin result = src; mem_rd = 1'b1; end
            OP_STORE:  begin result = src; store_data = dst; mem_wr = 1'b1; end
            OP_CMP: begin
                next_flags[FLAG_L] = (src < dst);
                next_flags[FLAG_G] = (src > dst);
                next_flags[FLAG_E] = (src == dst);
            end
            OP_JUMP:   begin target = br_tgt; taken = 1'b1; end
            OP_JUMPL:  begin target = br_tgt; taken = flags[FLAG_L]; end
            OP_JUMPG:  begin target = br_tgt; taken = flags[FLAG_G]; end
            OP_JUMPE:  begin target = br_tgt; taken = flags[FLAG_E]; end
            OP_JUMPNE: begin target = br_tgt; taken = !flags[FLAG_E]; end
            OP_JUMPLI: begin target = br_tgt; taken = 1'b1; result = npc; we = 1'b1; end
            OP_RET:    begin target = src;    taken = 1'b1; end
            default:   illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/exec_unit.sv
// Execute stage: input/output valid-ready handshake, one output register
// and the compare-flag register around the combinational exec_alu.
module exec_unit
    import exec_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int IMM_W  = 5,
    parameter int RIDX_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        in_op,
    input  logic [DATA_W-1:0] in_src,
    input  logic [DATA_W-1:0] in_dst,
    input  logic [RIDX_W-1:0] in_dst_idx,
    input  logic [IMM_W-1:0]  in_imm,
    input  logic [DATA_W-1:0] in_npc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic [DATA_W-1:0] out_store_data,
    output logic [RIDX_W-1:0] out_dst_idx,
    output logic              out_we,
    output logic              out_mem_rd,
    output logic              out_mem_wr,
    output logic              out_br_taken,
    output logic [DATA_W-1:0] out_br_target,
    output logic              out_illegal,
    output logic [2:0]        flags
);

    logic              accept;
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] alu_store_data;
    logic [DATA_W-1:0] alu_target;
    logic [2:0]        alu_next_flags;
    exec_ctrl_t        alu_ctrl;

    logic              out_valid_q, out_valid_d;
    exec_ctrl_t        ctrl_q, ctrl_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic [DATA_W-1:0] store_data_q, store_data_d;
    logic [DATA_W-1:0] target_q, target_d;
    logic [RIDX_W-1:0] dst_idx_q, dst_idx_d;
    logic [2:0]        flags_q, flags_d;

    exec_alu #(
        .DATA_W (DATA_W),
        .IMM_W  (IMM_W)
    ) u_alu (
        .op         (in_op),
        .src        (in_src),
        .dst        (in_dst),
        .imm        (in_imm),
        .npc        (in_npc),
        .flags      (flags_q),
        .result     (alu_result),
        .store_data (alu_store_data),
        .we         (alu_ctrl.we),
        .mem_rd     (alu_ctrl.mem_rd),
        .mem_wr     (alu_ctrl.mem_wr),
        .taken      (alu_ctrl.br_taken),
        .target     (alu_target),
        .illegal    (alu_ctrl.illegal),
        .next_flags (alu_next_flags)
    );

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready && !flush;

    // Next output-stage contents: flush wins, then accept, then drain to empty (cleared so controls read 0)
    always_comb begin
        out_valid_d  = out_valid_q;
        ctrl_d       = ctrl_q;
        result_d     = result_q;
        store_data_d = store_data_q;
        target_d     = target_q;
        dst_idx_d    = dst_idx_q;
        flags_d      = flags_q;
        if (flush || (!accept && out_ready)) begin
            out_valid_d  = 1'b0;
            ctrl_d       = '0;
            result_d     = '0;
            store_data_d = '0;
            target_d     = '0;
            dst_idx_d    = '0;
        end else if (accept) begin
            out_valid_d  = 1'b1;
            ctrl_d       = alu_ctrl;
            result_d     = alu_result;
            store_data_d = alu_store_data;
            target_d     = alu_target;
            dst_idx_d    = in_dst_idx;
            flags_d      = alu_next_flags;
        end
    end

    // Output register and flag register with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            ctrl_q       <= '0;
            result_q     <= '0;
            store_data_q <= '0;
            target_q     <= '0;
            dst_idx_q    <= '0;
            flags_q      <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            ctrl_q       <= ctrl_d;
            result_q     <= result_d;
            store_data_q <= store_data_d;
            target_q     <= target_d;
            dst_idx_q    <= dst_idx_d;
            flags_q      <= flags_d;
        end
    end

    assign out_valid      = out_valid_q;
    assign out_result     = result_q;
    assign out_store_data = store_data_q;
    assign out_dst_idx    = dst_idx_q;
    assign out_we         = ctrl_q.we;
    assign out_mem_rd     = ctrl_q.mem_rd;
    assign out_mem_wr     = ctrl_q.mem_wr;
    assign out_br_taken   = ctrl_q.br_taken;
    assign out_br_target  = target_q;
    assign out_illegal    = ctrl_q.illegal;
    assign flags          = flags_q;

endmodule

// File: tb/tb_exec_unit.sv
// Self-checking bench for exec_unit: a reference model predicts each
// accepted instruction into a scoreboard queue, checked while it sits in
// the output stage and retired when MEM takes it.
module tb_exec_unit;
    import exec_pkg::*;

    localparam int DATA_W = 16;
    localparam int IMM_W  = 5;
    localparam int RIDX_W = 3;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              flush = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [4:0]        in_op = '0;
    logic [DATA_W-1:0] in_src = '0;
    logic [DATA_W-1:0] in_dst = '0;
    logic [RIDX_W-1:0] in_dst_idx = '0;
    logic [IMM_W-1:0]  in_imm = '0;
    logic [DATA_W-1:0] in_npc = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [DATA_W-1:0] out_result;
    logic [DATA_W-1:0] out_store_data;
    logic [RIDX_W-1:0] out_dst_idx;
    logic              out_we;
    logic              out_mem_rd;
    logic              out_mem_wr;
    logic              out_br_taken;
    logic [DATA_W-1:0] out_br_target;
    logic              out_illegal;
    logic [2:0]        flags;

    exec_unit #(
        .DATA_W (DATA_W),
        .IMM_W  (IMM_W),
        .RIDX_W (RIDX_W)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_op          (in_op),
        .in_src         (in_src),
        .in_dst         (in_dst),
        .in_dst_idx     (in_dst_idx),
        .in_imm         (in_imm),
        .in_npc         (in_npc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_result     (out_result),
        .out_store_data (out_store_data),
        .out_dst_idx    (out_dst_idx),
        .out_we         (out_we),
        .out_mem_rd     (out_mem_rd),
        .out_mem_wr     (out_mem_wr),
        .out_br_taken   (out_br_taken),
        .out_br_target  (out_br_target),
        .out_illegal    (out_illegal),
        .flags          (flags)
    );

    // Free-running clock, 10 time units per period
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] result;
        logic [15:0] store_data;
        logic [15:0] target;
        logic [2:0]  dst_idx;
        logic        we;
        logic        rd;
        logic        wr;
        logic        taken;
        logic        illegal;
    } exp_t;

    exp_t        sb[$];
    logic        mv = 1'b0;
    logic [2:0]  mflags = 3'b000;
    int          n_checks = 0;
    int          n_pass = 0;

    logic [4:0]  r_op;
    logic [15:0] r_src, r_dst, r_npc;
    logic [2:0]  r_idx;
    logic [4:0]  r_imm;
    logic        r_v, r_rdy, r_fl;

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    // Reference behaviour of one instruction given the current model flags
    function automatic exp_t model(input logic [4:0] op, input logic [15:0] src, input logic [15:0] dst,
                                   input logic [2:0] idx, input logic [4:0] imm, input logic [15:0] npc,
                                   input logic [2:0] f);
        exp_t e;
        logic [15:0] tgt;
        e = '{default: '0};
        e.dst_idx = idx;
        tgt = npc + {{11{imm[4]}}, imm};
        case (op)
            OP_ADD:    begin e.result = src + dst; e.we = 1; end
            OP_SUB:    begin e.result = src - dst; e.we = 1; end
            OP_ADDI:   begin e.result = src + {11'b0, imm}; e.we = 1; end
            OP_SHLLI:  begin e.result = (imm >= 5'd16) ? 16'h0 : (src << imm); e.we = 1; end
            OP_SHRLI:  begin e.result = (imm >= 5'd16) ? 16'h0 : (src >> imm); e.we = 1; end
            OP_LOADI:  begin e.result = {11'b0, imm}; e.we = 1; end
            OP_MOV:    begin e.result = dst; e.we = 1; end
            OP_LOAD:   begin e.result = src; e.rd = 1; end
            OP_STORE:  begin e.result = src; e.store_data = dst; e.wr = 1; end
            OP_CMP:    ;
            OP_JUMP:   begin e.taken = 1; e.target = tgt; end
            OP_JUMPL:  begin e.taken = f[2]; e.target = tgt; end
            OP_JUMPG:  begin e.taken = f[1]; e.target = tgt; end
            OP_JUMPE:  begin e.taken = f[0]; e.target = tgt; end
            OP_JUMPNE: begin e.taken = !f[0]; e.target = tgt; end
            OP_JUMPLI: begin e.taken = 1; e.target = tgt; e.result = npc; e.we = 1; end
            OP_RET:    begin e.taken = 1; e.target = src; end
            default:   e.illegal = 1;
        endcase
        return e;
    endfunction

    // Compare the output stage against the oldest scoreboard entry
    task automatic checkFront(input string name);
        exp_t e;
        e = sb[0];
        checkOutput({name, ".we"}, out_we, e.we);
        checkOutput({name, ".mem_rd"}, out_mem_rd, e.rd);
        checkOutput({name, ".mem_wr"}, out_mem_wr, e.wr);
        checkOutput({name, ".br_taken"}, out_br_taken, e.taken);
        checkOutput({name, ".illegal"}, out_illegal, e.illegal);
        if (e.we || e.rd || e.wr) checkOutput({name, ".result"}, out_result, e.result);
        if (e.we || e.rd) checkOutput({name, ".dst_idx"}, out_dst_idx, e.dst_idx);
        if (e.wr) checkOutput({name, ".store_data"}, out_store_data, e.store_data);
        if (e.taken) checkOutput({name, ".target"}, out_br_target, e.target);
    endtask

    // Drive one cycle of stimulus, check the stage, then advance the model to the next edge
    task automatic applyStimulus(input string name, input logic v, input logic [4:0] op,
                                 input logic [15:0] src, input logic [15:0] dst, input logic [2:0] idx,
                                 input logic [4:0] imm, input logic [15:0] npc,
                                 input logic rdy, input logic fl);
        logic acc;
        @(negedge clk);
        in_valid = v; in_op = op; in_src = src; in_dst = dst; in_dst_idx = idx;
        in_imm = imm; in_npc = npc; out_ready = rdy; flush = fl;
        #1;
        checkOutput({name, ".in_ready"}, in_ready, (!mv || rdy));
        checkOutput({name, ".out_valid"}, out_valid, mv);
        checkOutput({name, ".flags"}, flags, mflags);
        if (mv && sb.size() > 0) begin
            checkFront(name);
        end else begin
            checkOutput({name, ".idle_ctrl"},
                        {out_we, out_mem_rd, out_mem_wr, out_br_taken, out_illegal}, 5'b0);
        end
        acc = v && (!mv || rdy) && !fl;
        if (fl) begin
            sb.delete();
            mv = 1'b0;
        end else begin
            if (mv && rdy) begin
                void'(sb.pop_front());
                mv = 1'b0;
            end
            if (acc) begin
                sb.push_back(model(op, src, dst, idx, imm, npc, mflags));
                mv = 1'b1;
                if (op == OP_CMP) mflags = {src < dst, src > dst, src == dst};
            end
        end
    endtask

    // Directed scenarios, a randomised stretch, then reset in the middle of a stall
    initial begin
        $display("[TB] exec_unit bench starting");
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        checkOutput("reset.out_valid", out_valid, 1'b0);
        checkOutput("reset.in_ready", in_ready, 1'b1);
        checkOutput("reset.flags", flags, 3'b000);
        checkOutput("reset.result", out_result, 16'h0);
        rst_n = 1'b1;

        applyStimulus("add",    1, OP_ADD,    16'h0007, 16'h0009, 3'd5, 5'd0,  16'h0, 1, 0);
        applyStimulus("sub",    1, OP_SUB,    16'h0000, 16'h0001, 3'd2, 5'd0,  16'h0, 1, 0);
        applyStimulus("shlli",  1, OP_SHLLI,  16'h0001, 16'h0000, 3'd3, 5'd16, 16'h0, 1, 0);
        applyStimulus("shrli",  1, OP_SHRLI,  16'h8000, 16'h0000, 3'd1, 5'd3,  16'h0, 1, 0);
        applyStimulus("addi",   1, OP_ADDI,   16'hFFFF, 16'h0000, 3'd6, 5'd1,  16'h0, 1, 0);
        applyStimulus("loadi",  1, OP_LOADI,  16'h0000, 16'h0000, 3'd7, 5'h1F, 16'h0, 1, 0);
        applyStimulus("mov",    1, OP_MOV,    16'h0000, 16'h1234, 3'd4, 5'd0,  16'h0, 1, 0);
        applyStimulus("cmp35",  1, OP_CMP,    16'd3,    16'd5,    3'd0, 5'd0,  16'h0, 1, 0);
        applyStimulus("jumpl",  1, OP_JUMPL,  16'h0000, 16'h0000, 3'd0, 5'b11110, 16'h0100, 1, 0);
        applyStimulus("jumpg",  1, OP_JUMPG,  16'h0000, 16'h0000, 3'd0, 5'd4,  16'h0100, 1, 0);
        applyStimulus("cmp55",  1, OP_CMP,    16'd5,    16'd5,    3'd0, 5'd0,  16'h0, 1, 0);
        applyStimulus("jumpne", 1, OP_JUMPNE, 16'h0000, 16'h0000, 3'd0, 5'd2,  16'h0040, 1, 0);
        applyStimulus("jumpe",  1, OP_JUMPE,  16'h0000, 16'h0000, 3'd0, 5'd2,  16'h0040, 1, 0);
        applyStimulus("ret",    1, OP_RET,    16'h0ABC, 16'h0000, 3'd0, 5'd0,  16'h0, 1, 0);
        applyStimulus("jumpli", 1, OP_JUMPLI, 16'h0000, 16'h0000, 3'd1, 5'd3,  16'h0200, 1, 0);
        applyStimulus("jump",   1, OP_JUMP,   16'h0000, 16'h0000, 3'd0, 5'b10000, 16'h0010, 1, 0);
        applyStimulus("load",   1, OP_LOAD,   16'h0040, 16'h0000, 3'd4, 5'd0,  16'h0, 1, 0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus("stall", 1, OP_STORE, 16'h0080, 16'hBEEF, 3'd0, 5'd0, 16'h0, 0, 0);
        end
        applyStimulus("handoff", 1, OP_STORE, 16'h0080, 16'hBEEF, 3'd0, 5'd0, 16'h0, 1, 0);
        applyStimulus("mov2",    1, OP_MOV,   16'h0000, 16'h5A5A, 3'd3, 5'd0,  16'h0, 1, 0);
        applyStimulus("flush",   1, OP_CMP,   16'd9,    16'd1,    3'd0, 5'd0,  16'h0, 1, 1);
        applyStimulus("post_flush", 0, OP_ADD, 16'h0, 16'h0, 3'd0, 5'd0, 16'h0, 1, 0);
        applyStimulus("ill31",   1, 5'd31,    16'h1111, 16'h2222, 3'd5, 5'd1,  16'h0, 1, 0);
        applyStimulus("ill17",   1, 5'd17,    16'h1111, 16'h2222, 3'd5, 5'd1,  16'h0, 1, 0);
        applyStimulus("idle",    0, OP_ADD,   16'h0, 16'h0, 3'd0, 5'd0, 16'h0, 1, 0);

        for (int i = 0; i < 60; i++) begin
            r_op  = 5'($urandom_range(0, 31));
            r_src = 16'($urandom);
            r_dst = (i % 4 == 0) ? r_src : 16'($urandom);
            r_npc = 16'($urandom);
            r_idx = 3'($urandom_range(0, 7));
            r_imm = 5'($urandom_range(0, 31));
            r_v   = ($urandom_range(0, 4) != 0);
            r_rdy = ($urandom_range(0, 3) != 0);
            r_fl  = ($urandom_range(0, 15) == 0);
            applyStimulus("rand", r_v, r_op, r_src, r_dst, r_idx, r_imm, r_npc, r_rdy, r_fl);
        end

        applyStimulus("pre_cmp", 1, OP_CMP, 16'd1, 16'd2, 3'd0, 5'd0, 16'h0, 1, 0);
        applyStimulus("pre_add", 1, OP_ADD, 16'h0101, 16'h0202, 3'd6, 5'd0, 16'h0, 1, 0);
        applyStimulus("pre_stall", 0, OP_ADD, 16'h0, 16'h0, 3'd0, 5'd0, 16'h0, 0, 0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_mid.out_valid", out_valid, 1'b0);
        checkOutput("rst_mid.result", out_result, 16'h0);
        checkOutput("rst_mid.dst_idx", out_dst_idx, 3'd0);
        checkOutput("rst_mid.ctrl", {out_we, out_mem_rd, out_mem_wr, out_br_taken, out_illegal}, 5'b0);
        checkOutput("rst_mid.target", out_br_target, 16'h0);
        checkOutput("rst_mid.store", out_store_data, 16'h0);
        checkOutput("rst_mid.flags", flags, 3'b000);
        sb.delete();
        mv = 1'b0;
        mflags = 3'b000;
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus("post_rst", 1, OP_SUB, 16'h0010, 16'h0003, 3'd2, 5'd0, 16'h0, 1, 0);
        applyStimulus("final",    0, OP_ADD, 16'h0, 16'h0, 3'd0, 5'd0, 16'h0, 1, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
